// File: rtl/mshr_rsp_pkg.sv
// Shared D-cache miss-path types and widths used by the MSHR response stage.
package mshr_rsp_pkg;

  localparam int DCACHE_TAG_W        = 20;
  localparam int DCACHE_IDX_W        = 6;
  localparam int DCACHE_WORD_IN_BITS = 64;
  localparam int DEF_MEM_TAG_W       = 4;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    GET_S = 2'd1,
    GET_M = 2'd2,
    PUT_M = 2'd3
  } message_t;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_t;

  function automatic logic is_get(input message_t m);
    return (m == GET_S) || (m == GET_M);
  endfunction

endpackage

// File: rtl/mshr_rsp_pe.sv
// Lowest-index priority encoder: picks the first set bit of req.
module mshr_rsp_pe #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         vld
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mshr_rsp.sv
// MSHR response stage: issues bus commands, tracks outstanding fetches, emits fills.
// Define MSHR_RSP_BYPASS_EN for combinational (0-cycle) fill outputs.
module mshr_rsp
  import mshr_rsp_pkg::*;
#(
  parameter int RSP_NUM   = 8,
  parameter int RSP_IDX_W = 3,
  parameter int MEM_TAG_W = DEF_MEM_TAG_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           iss_en_i,
  input  logic [DCACHE_TAG_W-1:0]        iss_tag_i,
  input  logic [DCACHE_IDX_W-1:0]        iss_idx_i,
  input  logic [DCACHE_WORD_IN_BITS-1:0] iss_data_i,
  input  message_t                       iss_message_i,
  output logic                           iss_ack_o,
  output bus_command_t                   mem_cmd_o,
  output logic [63:0]                    mem_addr_o,
  output logic [63:0]                    mem_data_o,
  input  logic [MEM_TAG_W-1:0]           mem_rsp_tag_i,
  input  logic [MEM_TAG_W-1:0]           mem_tag_i,
  input  logic [63:0]                    mem_data_i,
  output logic                           fill_en_o,
  output logic [DCACHE_TAG_W-1:0]        fill_tag_o,
  output logic [DCACHE_IDX_W-1:0]        fill_idx_o,
  output logic [63:0]                    fill_data_o,
  output message_t                       fill_message_o,
  output logic                           full_o
);

  logic [RSP_NUM-1:0]      vld_q;
  logic [MEM_TAG_W-1:0]    mtag_q [RSP_NUM];
  logic [DCACHE_TAG_W-1:0] tag_q  [RSP_NUM];
  logic [DCACHE_IDX_W-1:0] idx_q  [RSP_NUM];
  message_t                msg_q  [RSP_NUM];

  logic [RSP_IDX_W-1:0]    free_idx;
  logic                    free_vld;
  logic                    alloc;
  logic                    hit_any;
  logic [RSP_IDX_W-1:0]    hit_idx;

  logic                    fill_en_d;
  logic [DCACHE_TAG_W-1:0] fill_tag_d;
  logic [DCACHE_IDX_W-1:0] fill_idx_d;
  logic [63:0]             fill_data_d;
  message_t                fill_msg_d;

  assign full_o = &vld_q;

  // Command path is purely combinational from the head-of-queue request.
  always_comb begin
    mem_cmd_o = BUS_NONE;
    if (iss_en_i) begin
      if (iss_message_i == PUT_M)
        mem_cmd_o = BUS_STORE;
      else if (is_get(iss_message_i) && !full_o)
        mem_cmd_o = BUS_LOAD;
    end
  end

  assign iss_ack_o  = (mem_cmd_o != BUS_NONE) && (mem_rsp_tag_i != '0);
  assign mem_addr_o = {{(64 - DCACHE_TAG_W - DCACHE_IDX_W - 3){1'b0}}, iss_tag_i, iss_idx_i, 3'b000};
  assign mem_data_o = iss_data_i;
  assign alloc      = iss_ack_o && is_get(iss_message_i) && free_vld;

  mshr_rsp_pe #(
    .N (RSP_NUM),
    .W (RSP_IDX_W)
  ) u_pe (
    .req (~vld_q),
    .idx (free_idx),
    .vld (free_vld)
  );

  // Memory tags are unique, so at most one registered entry can hit.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < RSP_NUM; i++) begin
      if (vld_q[i] && (mem_tag_i != '0) && (mtag_q[i] == mem_tag_i)) begin
        hit_any = 1'b1;
        hit_idx = RSP_IDX_W'(i);
      end
    end
  end

  always_comb begin
    fill_en_d   = hit_any;
    fill_tag_d  = hit_any ? tag_q[hit_idx] : '0;
    fill_idx_d  = hit_any ? idx_q[hit_idx] : '0;
    fill_data_d = hit_any ? mem_data_i     : '0;
    fill_msg_d  = hit_any ? msg_q[hit_idx] : NONE;
  end

  // Allocation only targets free slots and retire only valid ones, so they never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RSP_NUM; i++) begin
        mtag_q[i] <= '0;
        tag_q[i]  <= '0;
        idx_q[i]  <= '0;
        msg_q[i]  <= NONE;
      end
    end else begin
      if (hit_any) begin
        vld_q[hit_idx]  <= 1'b0;
        mtag_q[hit_idx] <= '0;
        tag_q[hit_idx]  <= '0;
        idx_q[hit_idx]  <= '0;
        msg_q[hit_idx]  <= NONE;
      end
      if (alloc) begin
        vld_q[free_idx]  <= 1'b1;
        mtag_q[free_idx] <= mem_rsp_tag_i;
        tag_q[free_idx]  <= iss_tag_i;
        idx_q[free_idx]  <= iss_idx_i;
        msg_q[free_idx]  <= iss_message_i;
      end
    end
  end

`ifdef MSHR_RSP_BYPASS_EN
  assign fill_en_o      = fill_en_d;
  assign fill_tag_o     = fill_tag_d;
  assign fill_idx_o     = fill_idx_d;
  assign fill_data_o    = fill_data_d;
  assign fill_message_o = fill_msg_d;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_en_o      <= 1'b0;
      fill_tag_o     <= '0;
      fill_idx_o     <= '0;
      fill_data_o    <= '0;
      fill_message_o <= NONE;
    end else begin
      fill_en_o      <= fill_en_d;
      fill_tag_o     <= fill_tag_d;
      fill_idx_o     <= fill_idx_d;
      fill_data_o    <= fill_data_d;
      fill_message_o <= fill_msg_d;
    end
  end
`endif

endmodule

// File: tb/tb_mshr_rsp.sv
// Directed bench for mshr_rsp: command/ack checks per step, fills checked against a scoreboard.
module tb_mshr_rsp;
  import mshr_rsp_pkg::*;

  localparam int RSP_NUM = 8;
`ifdef MSHR_RSP_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [DCACHE_TAG_W-1:0] tag;
    logic [DCACHE_IDX_W-1:0] idx;
    logic [63:0]             data;
    message_t                msg;
  } fill_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    iss_en_i = 1'b0;
  logic [DCACHE_TAG_W-1:0] iss_tag_i = '0;
  logic [DCACHE_IDX_W-1:0] iss_idx_i = '0;
  logic [63:0]             iss_data_i = '0;
  message_t                iss_message_i = NONE;
  logic                    iss_ack_o;
  bus_command_t            mem_cmd_o;
  logic [63:0]             mem_addr_o;
  logic [63:0]             mem_data_o;
  logic [3:0]              mem_rsp_tag_i = '0;
  logic [3:0]              mem_tag_i = '0;
  logic [63:0]             mem_data_i = '0;
  logic                    fill_en_o;
  logic [DCACHE_TAG_W-1:0] fill_tag_o;
  logic [DCACHE_IDX_W-1:0] fill_idx_o;
  logic [63:0]             fill_data_o;
  message_t                fill_message_o;
  logic                    full_o;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  fill_t exp_q[$];
  int    due_q[$];
  fill_t model[int];

  mshr_rsp #(.RSP_NUM(RSP_NUM), .RSP_IDX_W(3), .MEM_TAG_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iss_en_i       (iss_en_i),
    .iss_tag_i      (iss_tag_i),
    .iss_idx_i      (iss_idx_i),
    .iss_data_i     (iss_data_i),
    .iss_message_i  (iss_message_i),
    .iss_ack_o      (iss_ack_o),
    .mem_cmd_o      (mem_cmd_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_rsp_tag_i  (mem_rsp_tag_i),
    .mem_tag_i      (mem_tag_i),
    .mem_data_i     (mem_data_i),
    .fill_en_o      (fill_en_o),
    .fill_tag_o     (fill_tag_o),
    .fill_idx_o     (fill_idx_o),
    .fill_data_o    (fill_data_o),
    .fill_message_o (fill_message_o),
    .full_o         (full_o)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // One cycle of stimulus: drive, check command path, update model and scoreboard.
  task automatic step(input logic en, input message_t msg, input logic [DCACHE_TAG_W-1:0] tag,
                      input logic [DCACHE_IDX_W-1:0] idx, input logic [63:0] data,
                      input logic [3:0] rsp, input logic [3:0] mtag, input logic [63:0] mdata);
    bus_command_t ecmd;
    logic         eack;
    logic [63:0]  eaddr;
    fill_t        f;
    int           cnt;
    @(posedge clk); #1;
    iss_en_i      = en;
    iss_message_i = msg;
    iss_tag_i     = tag;
    iss_idx_i     = idx;
    iss_data_i    = data;
    mem_rsp_tag_i = rsp;
    mem_tag_i     = mtag;
    mem_data_i    = mdata;
    cnt  = model.num();
    ecmd = BUS_NONE;
    if (en && msg == PUT_M) ecmd = BUS_STORE;
    else if (en && (msg == GET_S || msg == GET_M) && cnt < RSP_NUM) ecmd = BUS_LOAD;
    eack  = (ecmd != BUS_NONE) && (rsp != 4'd0);
    eaddr = (64'(tag) << (DCACHE_IDX_W + 3)) | (64'(idx) << 3);
    #1;
    chk("mem_cmd", 64'(mem_cmd_o), 64'(ecmd));
    chk("iss_ack", 64'(iss_ack_o), 64'(eack));
    chk("full", 64'(full_o), 64'(cnt == RSP_NUM));
    if (en) begin
      chk("mem_addr", mem_addr_o, eaddr);
      chk("mem_data", mem_data_o, data);
    end
    if (mtag != 4'd0 && model.exists(int'(mtag))) begin
      f      = model[int'(mtag)];
      f.data = mdata;
      exp_q.push_back(f);
      due_q.push_back(cyc + LAT);
      model.delete(int'(mtag));
    end
    if (eack && (msg == GET_S || msg == GET_M)) begin
      tests++;
      assert (!model.exists(int'(rsp))) else begin
        fails++;
        $error("FAIL dup_tag: got tag %0d already outstanding expected unique", rsp);
      end
      model[int'(rsp)] = fill_t'{tag, idx, 64'h0, msg};
    end
  endtask

  task automatic idle(input logic [3:0] mtag, input logic [63:0] mdata);
    step(1'b0, NONE, '0, '0, 64'h0, 4'd0, mtag, mdata);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    iss_en_i = 1'b0;
    mem_rsp_tag_i = '0;
    mem_tag_i = '0;
    repeat (2) @(posedge clk);
    #1;
    model.delete();
    chk("rst_full", 64'(full_o), 64'(0));
    chk("rst_fill_en", 64'(fill_en_o), 64'(0));
    chk("rst_fill_tag", 64'(fill_tag_o), 64'(0));
    chk("rst_fill_idx", 64'(fill_idx_o), 64'(0));
    chk("rst_fill_data", fill_data_o, 64'(0));
    chk("rst_fill_msg", 64'(fill_message_o), 64'(NONE));
    rst_n = 1'b1;
  endtask

  // Fill monitor: sampled mid-cycle, compares against the scoreboard head when it is due.
  always @(negedge clk) begin : mon
    logic  exp_en;
    fill_t f;
    while (due_q.size() > 0 && due_q[0] < cyc) begin
      tests++;
      fails++;
      $error("FAIL fill_missing: got none expected fill due at cycle %0d", due_q[0]);
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end
    exp_en = (due_q.size() > 0) && (due_q[0] == cyc);
    chk("fill_en", 64'(fill_en_o), 64'(exp_en));
    if (exp_en) begin
      f = exp_q.pop_front();
      void'(due_q.pop_front());
      chk("fill_tag", 64'(fill_tag_o), 64'(f.tag));
      chk("fill_idx", 64'(fill_idx_o), 64'(f.idx));
      chk("fill_data", fill_data_o, f.data);
      chk("fill_msg", 64'(fill_message_o), 64'(f.msg));
    end
  end

  initial begin
    do_reset();

    // Single GET_S round trip.
    step(1'b1, GET_S, 20'h12, 6'd3, 64'h0, 4'd5, 4'd0, 64'h0);
    idle(4'd5, 64'hDEAD);
    idle(4'd0, 64'h0);

    // PUT_M is fire-and-forget; its tag later returns nothing.
    step(1'b1, PUT_M, 20'h34, 6'd1, 64'hCAFE_F00D_1234_5678, 4'd7, 4'd0, 64'h0);
    idle(4'd0, 64'h0);
    idle(4'd7, 64'h1111);
    idle(4'd0, 64'h0);

    // Fill all entries with tags 1..8.
    for (int i = 1; i <= RSP_NUM; i++)
      step(1'b1, (i % 2) ? GET_S : GET_M, 20'($urandom_range(0, 20'hFFFFF)),
           6'($urandom_range(0, 63)), 64'h0, 4'(i), 4'd0, 64'h0);
    // 9th GET stalls while full even though tag 3 retires this cycle; accepted next cycle.
    step(1'b1, GET_M, 20'hABCDE, 6'd9, 64'h0, 4'd9, 4'd3, 64'h3333);
    step(1'b1, GET_M, 20'hABCDE, 6'd9, 64'h0, 4'd9, 4'd0, 64'h0);
    idle(4'd0, 64'h0);

    // Rejected GET_M (tag 0), then retry with tag 4 after tag 4 retires.
    idle(4'd4, 64'h4444);
    step(1'b1, GET_M, 20'h00777, 6'd21, 64'h0, 4'd0, 4'd0, 64'h0);
    step(1'b1, GET_M, 20'h00777, 6'd21, 64'h0, 4'd4, 4'd0, 64'h0);

    // Drain everything in scrambled order, including an unknown tag.
    idle(4'd2, 64'h2222);
    idle(4'd1, 64'h1);
    idle(4'd15, 64'hFFFF);
    idle(4'd9, 64'h9999);
    idle(4'd4, 64'h4004);
    for (int t = 5; t <= 8; t++)
      idle(4'(t), 64'($urandom));
    idle(4'd0, 64'h0);

    // Out-of-order returns 2,1,3.
    step(1'b1, GET_S, 20'h00A01, 6'd1, 64'h0, 4'd1, 4'd0, 64'h0);
    step(1'b1, GET_M, 20'h00A02, 6'd2, 64'h0, 4'd2, 4'd0, 64'h0);
    step(1'b1, GET_S, 20'h00A03, 6'd3, 64'h0, 4'd3, 4'd0, 64'h0);
    idle(4'd2, 64'hB2);
    idle(4'd1, 64'hB1);
    idle(4'd3, 64'hB3);
    idle(4'd0, 64'h0);

    // Mid-operation reset with three outstanding entries.
    step(1'b1, GET_S, 20'h0C00A, 6'd10, 64'h0, 4'd10, 4'd0, 64'h0);
    step(1'b1, GET_M, 20'h0C00B, 6'd11, 64'h0, 4'd11, 4'd0, 64'h0);
    step(1'b1, GET_S, 20'h0C00C, 6'd12, 64'h0, 4'd12, 4'd0, 64'h0);
    idle(4'd0, 64'h0);
    do_reset();
    idle(4'd11, 64'hBAD);
    idle(4'd0, 64'h0);
    idle(4'd0, 64'h0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
